ram64_march_bist: RTL and testbench

//  March C- built-in self-test controller: initiator side of the RAM64 port (in/load/address/out).
//  - Drives write data, load and address.
//  - Checks read data each cycle against the expected pattern.
//  - Reports pass/fail with first-failure diagnostics.
//  - Sits between the board test sequencer and one RAM64 instance.
//  - Muxed with the CPU data path while busy=1.

---
 rtl/ram64_march_bist_if.sv | 34 +++
 rtl/ram64_march_bist.sv | 165 ++++++++++++++++
 tb/tb_ram64_march_bist.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ram64_march_bist_if.sv
// rtl/ram64_march_bist_if.sv - RAM64 port bundle between the BIST initiator and one RAM64 instance
//
// Purpose: groups the RAM64 in/load/address/out signals.
// Modports:
//   master  BIST side: drives ram_in, ram_load, ram_address; samples ram_out
//   slave   RAM side : samples ram_in, ram_load, ram_address; drives ram_out
// Signals:
//   ram_in       WIDTH   write data
//   ram_load     1       write enable, commits on the next rising edge
//   ram_address  ADDR_W  word address
//   ram_out      WIDTH   combinational read data of ram_address
interface ram64_march_bist_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 6
);
   logic [WIDTH-1:0]  ram_in;
   logic              ram_load;
   logic [ADDR_W-1:0] ram_address;
   logic [WIDTH-1:0]  ram_out;

   modport master (
      output ram_in,
      output ram_load,
      output ram_address,
      input  ram_out
   );

   modport slave (
      input  ram_in,
      input  ram_load,
      input  ram_address,
      output ram_out
   );
endinterface

// File: rtl/ram64_march_bist.sv
// rtl/ram64_march_bist.sv - March C- built-in self-test controller for one RAM64
//
// Purpose: runs March C- (M0..M5) over a 2**ADDR_W word RAM, one op per clock,
//          and reports pass or the first mismatch (element, address, data read).
// Ports:
//   clk        in   1       rising-edge clock, shared with the RAM
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       level, sampled only in IDLE
//   busy       out  1       high during the RUN cycles
//   done       out  1       one-cycle pulse at end of run (pass or abort)
//   pass       out  1       last run was clean; held until the next start
//   fail_elem  out  3       march element of the first mismatch
//   fail_addr  out  ADDR_W  address of the first mismatch
//   fail_data  out  WIDTH   word read at the first mismatch
//   ram        master modport of ram64_march_bist_if (ram_in/ram_load/ram_address/ram_out)
module ram64_march_bist #(
   parameter int               WIDTH   = 16,
   parameter int               ADDR_W  = 6,
   parameter logic [WIDTH-1:0] PATTERN = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2:0]           fail_elem,
   output logic [ADDR_W-1:0]    fail_addr,
   output logic [WIDTH-1:0]     fail_data,
   ram64_march_bist_if.master   ram
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [WIDTH-1:0]  D0       = PATTERN;
   localparam logic [WIDTH-1:0]  D1       = ~PATTERN;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   state_t            state, state_nx;
   logic [2:0]        elem, elem_nx;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic              phase, phase_nx;

   // op decode of the registered state
   logic              two_op;
   logic              down;
   logic              rd_op;
   logic              wr_op;
   logic [WIDTH-1:0]  exp_data;
   logic [WIDTH-1:0]  wr_data;
   logic [ADDR_W-1:0] last_addr;
   logic              mismatch;
   logic              start_run;
   logic              clean_end;

   // ------------------------------------------------------------------
   // state register (plus result registers)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         elem      <= '0;
         addr      <= '0;
         phase     <= 1'b0;
         pass      <= 1'b0;
         fail_elem <= '0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         state <= state_nx;
         elem  <= elem_nx;
         addr  <= addr_nx;
         phase <= phase_nx;
         if (start_run) begin
            pass      <= 1'b0;
            fail_elem <= '0;
            fail_addr <= '0;
            fail_data <= '0;
         end else if (mismatch) begin
            pass      <= 1'b0;
            fail_elem <= elem;
            fail_addr <= addr;
            fail_data <= ram.ram_out;
         end else if (clean_end) begin
            pass <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      elem_nx   = elem;
      addr_nx   = addr;
      phase_nx  = phase;
      start_run = 1'b0;
      clean_end = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_run = 1'b1;
               state_nx  = S_RUN;
               elem_nx   = 3'd0;
               addr_nx   = '0;
               phase_nx  = 1'b0;
            end
         end
         S_RUN: begin
            if (mismatch) begin
               state_nx = S_DONE;
            end else if (two_op && !phase) begin
               phase_nx = 1'b1;
            end else begin
               phase_nx = 1'b0;
               if (addr == last_addr) begin
                  if (elem == 3'd5) begin
                     clean_end = 1'b1;
                     state_nx  = S_DONE;
                  end else begin
                     // each element starts from its own end of the array:
                     // M3/M4 descend from the top, the others ascend from 0
                     elem_nx = elem + 3'd1;
                     addr_nx = (elem == 3'd2 || elem == 3'd3) ? ADDR_MAX : '0;
                  end
               end else begin
                  addr_nx = down ? addr - 1'b1 : addr + 1'b1;
               end
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // output decode (registered state only; ram_out feeds just the compare)
   // ------------------------------------------------------------------
   always_comb begin
      two_op    = (elem >= 3'd1) && (elem <= 3'd4);
      down      = (elem == 3'd3) || (elem == 3'd4);
      rd_op     = (elem == 3'd5) || (two_op && !phase);
      wr_op     = (elem == 3'd0) || (two_op && phase);
      last_addr = down ? '0 : ADDR_MAX;

      case (elem)
         3'd2, 3'd4: exp_data = D1;
         default:    exp_data = D0;
      endcase
      case (elem)
         3'd1, 3'd3: wr_data = D1;
         default:    wr_data = D0;
      endcase

      busy     = (state == S_RUN);
      done     = (state == S_DONE);
      mismatch = busy && rd_op && (ram.ram_out != exp_data);

      ram.ram_load    = busy && wr_op;
      ram.ram_in      = (busy && wr_op) ? wr_data : '0;
      ram.ram_address = busy ? addr : '0;
   end

endmodule

// File: tb/tb_ram64_march_bist.sv
// tb/tb_ram64_march_bist.sv - directed bench for ram64_march_bist with fault-injecting RAM64 models
module tb_ram64_march_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, start_b;
   logic        busy_a, done_a, pass_a;
   logic        busy_b, done_b, pass_b;
   logic [2:0]  fe_a, fe_b;
   logic [5:0]  fa_a, fa_b;
   logic [15:0] fd_a, fd_b;

   int n_cmp = 0;
   int n_bad = 0;
   int fault_mode = 0;   // 0 none, 1 stuck-at-1 bit3 @42, 2 write@5 flips bit0 @6

   ram64_march_bist_if #(.WIDTH(16), .ADDR_W(6)) ra ();
   ram64_march_bist_if #(.WIDTH(16), .ADDR_W(6)) rb ();

   ram64_march_bist #(.WIDTH(16), .ADDR_W(6), .PATTERN(16'h0000)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_elem(fe_a), .fail_addr(fa_a), .fail_data(fd_a),
      .ram(ra.master)
   );

   ram64_march_bist #(.WIDTH(16), .ADDR_W(6), .PATTERN(16'h5555)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_elem(fe_b), .fail_addr(fa_b), .fail_data(fd_b),
      .ram(rb.master)
   );

   // RAM64 models: combinational read, write on rising edge
   logic [15:0] mem_a [64];
   logic [15:0] mem_b [64];

   always_comb begin
      ra.ram_out = mem_a[ra.ram_address];
      if (fault_mode == 1 && ra.ram_address == 6'd42)
         ra.ram_out = mem_a[42] | 16'h0008;
   end

   always @(posedge clk) begin
      if (ra.ram_load) begin
         mem_a[ra.ram_address] <= ra.ram_in;
         if (fault_mode == 2 && ra.ram_address == 6'd5)
            mem_a[6] <= mem_a[6] ^ 16'h0001;
      end
   end

   always_comb rb.ram_out = mem_b[rb.ram_address];

   always @(posedge clk) begin
      if (rb.ram_load) mem_b[rb.ram_address] <= rb.ram_in;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulses start on DUT A and walks its run; cycle 1 is the first RUN cycle.
   task automatic run_a(input int budget, input int stop_at, input bit probe,
                        output int busy_n, output int done_at);
      busy_n  = 0;
      done_at = 0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (c > 1) @(negedge clk);
         if (probe) begin
            if (c == 1) begin
               check("m0_first_load", 32'(ra.ram_load), 1);
               check("m0_first_addr", 32'(ra.ram_address), 0);
               check("m0_first_in", 32'(ra.ram_in), 0);
            end
            if (c == 65) begin
               check("m1_read_load", 32'(ra.ram_load), 0);
               check("m1_read_in", 32'(ra.ram_in), 0);
            end
            if (c == 66) check("m1_write_in", 32'(ra.ram_in), 32'hFFFF);
            if (c == 321) check("m3_first_addr", 32'(ra.ram_address), 63);
         end
         if (c == stop_at) return;
         if (done_a) begin
            done_at = c;
            return;
         end
         if (busy_a) busy_n++;
      end
      check("run_timeout", 0, 1);
   endtask

   initial begin
      int nb, nd, busy2;
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_busy", 32'(busy_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_pass", 32'(pass_a), 0);
      check("rst_fail_elem", 32'(fe_a), 0);
      check("rst_fail_addr", 32'(fa_a), 0);
      check("rst_fail_data", 32'(fd_a), 0);
      check("rst_ram_load", 32'(ra.ram_load), 0);
      check("rst_ram_address", 32'(ra.ram_address), 0);
      check("rst_ram_in", 32'(ra.ram_in), 0);
      check("rst_b_ram_load", 32'(rb.ram_load), 0);

      rst_n = 1'b1;
      @(negedge clk);

      // fault-free run
      run_a(700, 0, 1'b1, nb, nd);
      check("t1_busy_cycles", 32'(nb), 640);
      check("t1_done_cycle", 32'(nd), 641);
      check("t1_pass", 32'(pass_a), 1);
      check("t1_fail_elem", 32'(fe_a), 0);
      check("t1_fail_addr", 32'(fa_a), 0);
      check("t1_fail_data", 32'(fd_a), 0);
      @(negedge clk);
      check("t1_done_pulse", 32'(done_a), 0);
      check("t1_pass_held", 32'(pass_a), 1);

      // stuck-at-1 on bit 3 of address 42
      fault_mode = 1;
      run_a(700, 0, 1'b0, nb, nd);
      check("t2_busy_cycles", 32'(nb), 149);
      check("t2_done_cycle", 32'(nd), 150);
      check("t2_fail_elem", 32'(fe_a), 1);
      check("t2_fail_addr", 32'(fa_a), 42);
      check("t2_fail_data", 32'(fd_a), 32'h0008);
      check("t2_pass", 32'(pass_a), 0);
      check("t2_no_access", 32'(ra.ram_load), 0);
      @(negedge clk);

      // coupling fault: write to 5 flips bit 0 of 6
      fault_mode = 2;
      run_a(700, 0, 1'b0, nb, nd);
      check("t3_done_cycle", 32'(nd), 78);
      check("t3_fail_elem", 32'(fe_a), 1);
      check("t3_fail_addr", 32'(fa_a), 6);
      check("t3_fail_data", 32'(fd_a), 32'h0001);
      check("t3_pass", 32'(pass_a), 0);
      @(negedge clk);

      // reset in the middle of a run, then a clean restart
      fault_mode = 0;
      run_a(700, 300, 1'b0, nb, nd);
      check("t4_load_before_rst", 32'(ra.ram_load), 1);
      rst_n = 1'b0;
      #1;
      check("t4_load_in_rst", 32'(ra.ram_load), 0);
      check("t4_busy_in_rst", 32'(busy_a), 0);
      check("t4_addr_in_rst", 32'(ra.ram_address), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_a(700, 0, 1'b0, nb, nd);
      check("t4_done_cycle", 32'(nd), 641);
      check("t4_pass", 32'(pass_a), 1);

      // PATTERN 5555, start held high -> back-to-back runs
      busy2   = 0;
      start_b = 1'b1;
      for (int c = 1; c <= 1290; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("b_m0_load", 32'(rb.ram_load), 1);
            check("b_m0_in", 32'(rb.ram_in), 32'h5555);
         end
         if (c == 66) check("b_m1_in", 32'(rb.ram_in), 32'hAAAA);
         if (c >= 321 && c <= 448)
            check("b_m3_addr", 32'(rb.ram_address), 32'(63 - (c - 321) / 2));
         if (c == 448) check("b_m3_last_load", 32'(rb.ram_load), 1);
         if (c == 641) begin
            check("b_run1_done", 32'(done_b), 1);
            check("b_run1_pass", 32'(pass_b), 1);
         end
         if (c == 642) check("b_idle_busy", 32'(busy_b), 0);
         if (c == 643) check("b_run2_busy", 32'(busy_b), 1);
         if (c >= 642 && busy_b) busy2++;
         if (c == 1283) begin
            check("b_run2_done", 32'(done_b), 1);
            check("b_run2_pass", 32'(pass_b), 1);
         end
         if (c == 1285) check("b_stays_idle", 32'(busy_b), 0);
         // start activity while busy must not disturb run 2
         if (c == 700)  start_b = 1'b0;
         if (c == 800)  start_b = 1'b1;
         if (c == 801)  start_b = 1'b0;
         if (c == 1000) start_b = 1'b1;
         if (c == 1001) start_b = 1'b0;
      end
      check("b_run2_busy_cycles", 32'(busy2), 640);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
